// File: rtl/calc_pkg.sv
// Shared encodings for the calculator display receiver: stream status codes,
// receiver FSM states and the active-low segment patterns used for "Erro".
package calc_pkg;

  localparam logic [1:0] ST_ERR   = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_COMMIT  = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  // Segment bit 0 = a ... bit 6 = g, active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_r     = 7'h2F;
  localparam logic [6:0] SEG_o     = 7'h23;

  function automatic logic [6:0] err_pattern(input int idx);
    case (idx)
      3:       return SEG_E;
      2, 1:    return SEG_r;
      0:       return SEG_o;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/calc_display_if.sv
// Digit stream from the calculator core: status plus one (pos, data) pair per clock.
interface calc_display_if;
  logic [1:0] status;
  logic [3:0] data;
  logic [3:0] pos;

  modport master (output status, data, pos);
  modport slave  (input  status, data, pos);
endinterface

// File: rtl/calc_display_seg7_decoder.sv
// BCD digit to active-low seven-segment pattern; non-decimal codes render blank.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_display.sv
// Captures the calculator digit stream into a shadow frame, commits complete frames
// to the display buffer and scans them onto a multiplexed seven-segment display.
module calc_display
  import calc_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int BLANK_LZ = 1,
  parameter int NDIG     = 8
) (
  input  logic             clock,
  input  logic             reset,
  calc_display_if.slave    stream,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  an,
  output logic             frame_valid,
  output logic             err
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(NDIG);

  state_t          state_reg, state_next;
  logic [3:0]      shadow_reg [NDIG];
  logic [3:0]      disp_reg   [NDIG];
  logic [NDIG-1:0] mask_reg, mask_next;
  logic            capture_en, commit_en, pos_ok;
  logic            frame_valid_reg, err_reg;

  logic [CW-1:0]   cnt_reg;
  logic [IW-1:0]   idx_reg, idx_next;
  logic            wrap;
  logic [6:0]      seg_reg, seg_next, dec_seg;
  logic [NDIG-1:0] an_reg, an_next;
  logic [NDIG-1:0] lz_blank;
  logic [NDIG-1:1] digit_zero;

  assign pos_ok = ({28'd0, stream.pos} < 32'(NDIG));

  always_comb begin
    state_next = state_reg;
    mask_next  = mask_reg;
    capture_en = 1'b0;
    commit_en  = 1'b0;
    if (stream.status == ST_ERR) begin
      state_next = S_ERROR;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (stream.status == ST_BUSY) begin
            state_next = S_CAPTURE;
            capture_en = pos_ok;
          end
        end
        S_CAPTURE: begin
          if (stream.status == ST_BUSY) begin
            capture_en = pos_ok;
          end else if (stream.status == ST_READY) begin
            if (&mask_reg) begin
              state_next = S_COMMIT;
            end else begin
              state_next = S_IDLE;
              mask_next  = '0;
            end
          end
        end
        S_COMMIT: begin
          commit_en  = 1'b1;
          mask_next  = '0;
          state_next = S_IDLE;
        end
        S_ERROR: state_next = S_ERROR;
        default: state_next = S_IDLE;
      endcase
    end
    if (capture_en) begin
      mask_next = mask_reg | (NDIG'(1) << stream.pos);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= S_IDLE;
      mask_reg        <= '0;
      frame_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      for (int i = 0; i < NDIG; i++) begin
        shadow_reg[i] <= 4'd0;
        disp_reg[i]   <= 4'd0;
      end
    end else begin
      state_reg <= state_next;
      mask_reg  <= mask_next;
      if (capture_en) begin
        shadow_reg[stream.pos[IW-1:0]] <= stream.data;
      end
      if (commit_en) begin
        disp_reg        <= shadow_reg;
        frame_valid_reg <= 1'b1;
      end
      if (state_next == S_ERROR) begin
        err_reg <= 1'b1;
      end
    end
  end

  // Digit i>0 is a leading zero when it and every higher digit are zero.
  assign lz_blank[0] = 1'b0;
  for (genvar gi = 1; gi < NDIG; gi++) begin : g_lz
    assign digit_zero[gi] = (disp_reg[gi] == 4'd0);
    assign lz_blank[gi]   = (BLANK_LZ != 0) && (&digit_zero[NDIG-1:gi]);
  end

  assign wrap     = (cnt_reg == CW'(SCAN_DIV - 1));
  assign idx_next = (idx_reg == IW'(NDIG - 1)) ? '0 : idx_reg + IW'(1);

  seg7_decoder u_dec (
    .bcd (disp_reg[idx_next]),
    .seg (dec_seg)
  );

  // Anode and segments are loaded together at the slot boundary for the upcoming digit.
  always_comb begin
    an_next  = ~(NDIG'(1) << idx_next);
    seg_next = SEG_BLANK;
    if (err_reg) begin
      seg_next = err_pattern(int'(idx_next));
    end else if (!frame_valid_reg) begin
      an_next = '1;
    end else if (!lz_blank[idx_next]) begin
      seg_next = dec_seg;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
      idx_reg <= '0;
      seg_reg <= SEG_BLANK;
      an_reg  <= '1;
    end else if (wrap) begin
      cnt_reg <= '0;
      idx_reg <= idx_next;
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign seg         = seg_reg;
  assign an          = an_reg;
  assign frame_valid = frame_valid_reg;
  assign err         = err_reg;

endmodule

// File: tb/tb_calc_display.sv
// Scoreboard bench for calc_display: stimulus updates a frame-level reference model and
// queues the expected display; a monitor observes one full scan per queued expectation.
module tb_calc_display;

  localparam int SCAN_DIV = 4;
  localparam int NDIG     = 8;
  localparam int SETTLE   = SCAN_DIV + 3;
  localparam int OBS      = (NDIG + 1) * SCAN_DIV + 4;

  typedef struct packed {
    logic            dark;
    logic            fv;
    logic            er;
    logic [7:0][6:0] segs;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_valid, err;

  calc_display_if bus ();

  calc_display #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_LZ (1),
    .NDIG     (NDIG)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stream      (bus),
    .seg         (seg),
    .an          (an),
    .frame_valid (frame_valid),
    .err         (err)
  );

  always #5 clock = ~clock;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  logic [3:0] m_shadow [8];
  logic [3:0] m_disp   [8];
  logic [7:0] m_mask;
  bit         m_valid, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [6:0] pat(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t expect_now();
    exp_t e;
    int   msd = 0;
    e.dark = !m_err && !m_valid;
    e.fv   = m_valid;
    e.er   = m_err;
    for (int i = 0; i < 8; i++) if (m_disp[i] != 0) msd = i;
    for (int i = 0; i < 8; i++) begin
      if (m_err)
        e.segs[i] = (i == 3) ? 7'h06 : (i == 2 || i == 1) ? 7'h2F : (i == 0) ? 7'h23 : 7'h7F;
      else
        e.segs[i] = (i > msd) ? 7'h7F : pat(m_disp[i]);
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = 4'd0;
      m_disp[i]   = 4'd0;
    end
    m_mask  = 8'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  task automatic do_reset();
    bus.status = 2'b10;
    bus.data   = 4'd0;
    bus.pos    = 4'd0;
    reset      = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  task automatic busy(input int p, input int d);
    bus.status = 2'b01;
    bus.pos    = 4'(p);
    bus.data   = 4'(d);
    if (!m_err && p < 8) begin
      m_shadow[p] = 4'(d);
      m_mask[p]   = 1'b1;
    end
    @(negedge clock);
  endtask

  task automatic hold();
    bus.status = 2'b11;
    @(negedge clock);
  endtask

  task automatic ready();
    bus.status = 2'b10;
    if (!m_err) begin
      if (m_mask == 8'hFF) begin
        m_disp  = m_shadow;
        m_valid = 1'b1;
      end
      m_mask = 8'd0;
    end
    @(negedge clock);
  endtask

  task automatic settle_check();
    bus.status = 2'b10;
    repeat (SETTLE) @(negedge clock);
    exp_q.push_back(expect_now());
    repeat (OBS) @(negedge clock);
  endtask

  task automatic frame(input logic [31:0] digits);
    for (int p = 0; p < 8; p++) busy(p, int'(digits[4*p +: 4]));
    ready();
    settle_check();
  endtask

  task automatic raise_error();
    bus.status = 2'b00;
    m_err      = 1'b1;
    @(negedge clock);
    check("err_next_clock", 32'(err), 32'd1);
    bus.status = 2'b10;
  endtask

  task automatic rand_frame();
    int ps[$];
    int top, tmp, j, d;
    bit full;
    full = ($urandom_range(0, 3) != 0);
    top  = $urandom_range(1, 8);
    for (int p = 0; p < 8; p++) if (full || $urandom_range(0, 1) == 1) ps.push_back(p);
    repeat ($urandom_range(0, 2)) ps.push_back($urandom_range(0, 15));
    for (int i = ps.size() - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = ps[i]; ps[i] = ps[j]; ps[j] = tmp;
    end
    foreach (ps[k]) begin
      tmp = $urandom_range(0, 9);
      d = (tmp < 3 || (ps[k] >= top && ps[k] < 8)) ? 0 :
          (tmp == 9) ? $urandom_range(10, 15) : $urandom_range(1, 9);
      if ($urandom_range(0, 4) == 0) hold();
      busy(ps[k], d);
    end
    ready();
    settle_check();
  endtask

  // Monitor: one queued expectation covers one full scan rotation.
  initial begin
    exp_t     e;
    bit [7:0] seen;
    int       idx;
    int       txn = 0;
    forever begin
      @(negedge clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        seen = '0;
        check("frame_valid", 32'(frame_valid), 32'(e.fv));
        check("err", 32'(err), 32'(e.er));
        for (int s = 0; s < NDIG; s++) begin
          if (e.dark) begin
            check("an_dark", 32'(an), 32'hFF);
            check("seg_dark", 32'(seg), 32'h7F);
          end else begin
            check("an_onehot", 32'($countones(~an)), 32'd1);
            idx = 0;
            for (int k = 0; k < 8; k++) if (!an[k]) idx = k;
            seen[idx] = 1'b1;
            check($sformatf("seg_digit%0d", idx), 32'(seg), 32'(e.segs[idx]));
          end
          if (s != NDIG - 1) repeat (SCAN_DIV) @(negedge clock);
        end
        if (!e.dark) check("digits_covered", 32'(seen), 32'hFF);
        $display("txn %0d: fv=%0b err=%0b dark=%0b segs=%h", txn, e.fv, e.er, e.dark, e.segs);
        txn++;
      end
    end
  end

  initial begin
    logic [7:0] prev;
    int         run;

    bus.status = 2'b10;
    bus.data   = 4'd0;
    bus.pos    = 4'd0;
    #1;
    do_reset();
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_fv", 32'(frame_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // 123 with leading-zero blanking and commit latency
    for (int p = 0; p < 8; p++) busy(p, (p < 3) ? 3 - p : 0);
    ready();
    check("fv_latency_1clk", 32'(frame_valid), 32'd0);
    @(negedge clock);
    check("fv_latency_2clk", 32'(frame_valid), 32'd1);
    settle_check();

    // Incomplete frame is dropped
    do_reset();
    for (int p = 0; p < 5; p++) busy(p, p + 1);
    ready();
    settle_check();

    // Error is sticky, ignores later frames
    do_reset();
    frame(32'h0000_0045);
    raise_error();
    settle_check();
    frame(32'h1111_1111);

    // Asynchronous reset during capture
    do_reset();
    frame(32'h0000_0045);
    busy(0, 9); busy(1, 9); busy(2, 9);
    bus.status = 2'b01; bus.pos = 4'd3; bus.data = 4'd9;
    #2;
    reset = 1'b0;
    #1;
    check("async_an", 32'(an), 32'hFF);
    check("async_seg", 32'(seg), 32'h7F);
    check("async_fv", 32'(frame_valid), 32'd0);
    @(negedge clock);
    bus.status = 2'b10;
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    @(negedge clock);
    frame(32'h0000_0098);

    // Out-of-range position and non-BCD digit
    busy(0, 1); busy(1, 2); busy(9, 7); busy(2, 12); busy(3, 4);
    for (int p = 4; p < 8; p++) busy(p, 0);
    ready();
    settle_check();

    // Scan rotation and slot length
    frame(32'h8765_4321);
    prev = an;
    run = 0;
    while (an == prev && run < 3 * SCAN_DIV) begin
      @(negedge clock);
      run++;
    end
    check("scan_sync", 32'(an != prev), 32'd1);
    for (int s = 0; s < NDIG + 2; s++) begin
      prev = an;
      run = 0;
      while (an == prev && run < 3 * SCAN_DIV) begin
        @(negedge clock);
        run++;
      end
      check("slot_len", 32'(run), 32'(SCAN_DIV));
      check("slot_next", 32'(an), 32'({prev[6:0], prev[7]}));
    end

    // Randomized frames with occasional errors
    do_reset();
    for (int t = 0; t < 25; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        raise_error();
        settle_check();
        rand_frame();
        do_reset();
      end else begin
        rand_frame();
      end
    end

    for (int i = 0; i < OBS && exp_q.size() != 0; i++) @(negedge clock);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
